cordic_sequencer: RTL

Upstream control stage for the iterative `cordic` core. It accepts target angles through a valid/ready port and buffers them in a 4-entry FIFO. For each angle it drives the core's `endangle`/`load`/`addr` sequence through all 16 micro-rotations. It then captures the resulting `sin`/`cos` into a registered output with valid/ready back-pressure, replacing the hand-stepped `addr`/`load` stimulus with a free-running, streaming front end.

---
 rtl/cordic_seq_pkg.sv | 16 +
 rtl/cordic_seq_fifo.sv | 55 +++++
 rtl/cordic_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cordic_seq_pkg.sv
// Shared types and defaults for the cordic front-end sequencer.
// State encoding plus default angle width, iteration count and addr width.
package cordic_seq_pkg;

  localparam int CORDIC_W      = 16;
  localparam int CORDIC_ITER   = 16;
  localparam int CORDIC_ADDR_W = $clog2(CORDIC_ITER);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_CAPT
  } seq_state_t;

endpackage

// File: rtl/cordic_seq_fifo.sv
// Synchronous DEPTH x W FIFO with count-based full/empty; head is the read data.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; no read-during-write bypass.
module cordic_seq_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_sequencer.sv
// Streams buffered angles through the iterative cordic core (load, addr 1..ITER-1) and registers sin/cos.
// Latency: result valid 18 edges after a push into an idle block; one result per ITER+1 cycles when streaming.
// Backpressure: stalls in CAPT while the output register is held; CORDIC_SEQ_STATS_EN adds op_count.
module cordic_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int W     = CORDIC_W,
  parameter int ITER  = CORDIC_ITER,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_angle,
  output logic [W-1:0]             cordic_endangle,
  output logic [$clog2(ITER)-1:0]  cordic_addr,
  output logic                     cordic_load,
  input  logic [W-1:0]             cordic_sin,
  input  logic [W-1:0]             cordic_cos,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_sin,
  output logic [W-1:0]             out_cos,
  output logic [W-1:0]             out_angle,
  output logic                     busy
`ifdef CORDIC_SEQ_STATS_EN
  ,
  output logic [15:0]              op_count
`endif
);

  localparam int            AW   = $clog2(ITER);
  localparam logic [AW-1:0] LAST = AW'(ITER - 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [AW-1:0] addr_nxt;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [W-1:0]  fifo_head;
  logic          cap;

  // Held in reset so no push can land while reset_n is low.
  assign in_ready    = reset_n & ~fifo_full;
  assign cordic_load = (state == ST_LOAD);
  assign busy        = (state != ST_IDLE);

  cordic_seq_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (in_valid & in_ready),
    .push_dat (in_angle),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = cordic_addr;
    fifo_pop  = 1'b0;
    cap       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          addr_nxt  = '0;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        addr_nxt  = AW'(1);
        state_nxt = ST_ITER;
      end
      ST_ITER: begin
        if (cordic_addr == LAST) begin
          state_nxt = ST_CAPT;
        end else begin
          addr_nxt = cordic_addr + AW'(1);
        end
      end
      ST_CAPT: begin
        // A same-cycle pop frees the register, so the new result lands with no bubble.
        if (!out_valid || out_ready) begin
          cap      = 1'b1;
          addr_nxt = '0;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        addr_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      cordic_addr     <= '0;
      cordic_endangle <= '0;
      out_valid       <= 1'b0;
      out_sin         <= '0;
      out_cos         <= '0;
      out_angle       <= '0;
    end else begin
      state       <= state_nxt;
      cordic_addr <= addr_nxt;
      if (fifo_pop) begin
        cordic_endangle <= fifo_head;
      end
      if (cap) begin
        out_valid <= 1'b1;
        out_sin   <= cordic_sin;
        out_cos   <= cordic_cos;
        out_angle <= cordic_endangle;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CORDIC_SEQ_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (cap && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule
